program_counter: RTL and testbench
==================================

# program_counter

Program counter for the SAP2 datapath, sitting directly downstream of the ALU flag registers. It holds the fetch address and performs increment, unconditional or conditional jump, CALL and RET. Conditions are evaluated against the ALU's latched zero, carry and odd flags. Return addresses live in a small internal hardware stack with sticky overflow and underflow error flags. Its output drives the memory address path and is read back onto the bus by microcode.

## Interface
- ADDR_WIDTH, 8 — width of the program address.
- STACK_DEPTH, 4 — number of return-stack entries; must be ≥ 1.
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  global clock enable; no state changes when low.
- i_inc  in  1  advance PC by one.
- i_jump  in  1  load i_target if the condition holds.
- i_call  in  1  push return address, then load i_target if the condition holds.
- i_ret  in  1  pop the top of stack into the PC.
- i_cond  in  COND_WIDTH (3)  condition select for i_jump / i_call.
- i_target  in  ADDR_WIDTH  jump or call destination.
- i_zero, i_carry, i_odd  in  1 each  latched ALU flags.
- i_clr_err  in  1  clear the sticky error flags.
- o_pc  out  ADDR_WIDTH  current program counter (registered).
- o_taken  out  1  combinational: the selected condition is true.
- o_depth  out  clog2(STACK_DEPTH+1)  number of occupied stack entries.
- o_stack_ovf  out  1  sticky: a CALL was attempted with the stack full.
- o_stack_unf  out  1  sticky: a RET was attempted with the stack empty.

## Operation
- Condition codes for i_cond:
  - 0 ALWAYS, 1 Z, 2 NZ, 3 C, 4 NC, 5 ODD, 6 EVEN, 7 NEVER.
  - o_taken decodes these from i_zero, i_carry and i_odd.
- Command priority when clk_en=1: i_ret > i_call > i_jump > i_inc. Only the highest asserted command acts.
- RET:
  - Stack non-empty: o_pc ← top of stack; depth −1.
  - Stack empty: o_pc unchanged; o_stack_unf ← 1.
- CALL:
  - o_taken=0: the call is a no-op. Control falls to i_inc if asserted, otherwise PC holds.
  - o_taken=1, stack not full: push o_pc (the address microcode has already advanced past the operand); o_pc ← i_target; depth +1.
  - o_taken=1, stack full: no push, o_pc unchanged, o_stack_ovf ← 1.
- JUMP:
  - o_taken=1: o_pc ← i_target.
  - o_taken=0: fall through to i_inc if asserted, otherwise PC holds.
- INC: o_pc ← o_pc + 1 modulo 2^ADDR_WIDTH, so all-ones wraps to 0.
- i_clr_err clears both sticky flags.
  - If an error event occurs in the same enabled cycle, the error wins and the flag stays set.
- Stack overwrite never occurs. Contents above the current depth are don't-care.

## Timing
- Reset (rst_n low, asynchronous): o_pc=0, depth=0, o_stack_ovf=0, o_stack_unf=0. Stack contents are undefined.
- Release of rst_n is synchronised by the integrator. The first edge after release may update state.
- Single-cycle latency: a command sampled on edge N is visible on o_pc after edge N.
- o_taken has zero latency and reflects the current i_cond and flag inputs.
- Flags are the ALU's registered outputs. A jump evaluates flags latched on an earlier enabled edge, never those being latched on the same edge. Microcode places the jump at least one enabled cycle after the ALU latch.
- clk_en=0 freezes all state, including sticky flags and the clear.
- Reset asserted mid-CALL or mid-RET takes precedence immediately; any partial push is discarded.

## Structure
- Condition-code constants (COND_ALWAYS … COND_NEVER) and COND_WIDTH belong in the shared control_words include, next to the ALU op codes.
- Sub-module `return_stack`:
  - Parameterised LIFO (ADDR_WIDTH × STACK_DEPTH).
  - push/pop inputs; top, full, empty and depth outputs.
  - Asynchronous active-low reset on the pointer only.
- Condition decode, priority logic and the PC register stay in program_counter.

## Test plan
- Reset, then i_inc held for 257 enabled cycles → o_pc counts 0…255, wraps to 0, ends at 1.
- o_pc=0x10, i_jump=1, i_cond=Z, i_zero=0, i_inc=1 → o_pc=0x11. Repeat with i_zero=1 and i_target=0x80 → o_pc=0x80.
- o_pc=0x22, i_call=1, i_cond=ALWAYS, i_target=0x40 → o_pc=0x40, depth=1. Then i_ret → o_pc=0x22, depth=0.
- Five nested CALLs with STACK_DEPTH=4 → fifth sets o_stack_ovf and leaves o_pc unchanged. Four RETs return in LIFO order. A fifth RET sets o_stack_unf.
- i_ret, i_call and i_inc together with depth=1 → RET wins, pop only. clk_en=0 with every command asserted → no state change.
- Sticky error set, then i_clr_err → flags clear. rst_n pulsed low mid-sequence between clock edges → all outputs 0 immediately.

Source files
------------

// File: rtl/program_counter_pkg.sv
// Shared control-word constants for the SAP2 sequencer: condition codes used by
// jump/call and the decode helper that turns them into a taken/not-taken bit.
package program_counter_pkg;

    localparam int unsigned COND_WIDTH = 3;

    typedef enum logic [COND_WIDTH-1:0] {
        COND_ALWAYS = 3'd0,
        COND_Z      = 3'd1,
        COND_NZ     = 3'd2,
        COND_C      = 3'd3,
        COND_NC     = 3'd4,
        COND_ODD    = 3'd5,
        COND_EVEN   = 3'd6,
        COND_NEVER  = 3'd7
    } cond_e;

    function automatic logic cond_taken(
        input logic [COND_WIDTH-1:0] cond,
        input logic                  zero,
        input logic                  carry,
        input logic                  odd
    );
        logic taken;
        taken = 1'b0;
        case (cond_e'(cond))
            COND_ALWAYS: taken = 1'b1;
            COND_Z:      taken = zero;
            COND_NZ:     taken = ~zero;
            COND_C:      taken = carry;
            COND_NC:     taken = ~carry;
            COND_ODD:    taken = odd;
            COND_EVEN:   taken = ~odd;
            COND_NEVER:  taken = 1'b0;
            default:     taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/return_stack.sv
// Small LIFO of return addresses. Only the occupancy pointer is reset; entry
// storage is plain flops whose contents above the pointer are don't-care.
module return_stack #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned STACK_DEPTH = 4,
    localparam int unsigned DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] push_data,
    output logic [ADDR_WIDTH-1:0] top,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_W-1:0]    depth
);

    logic [ADDR_WIDTH-1:0] mem [STACK_DEPTH];
    logic [DEPTH_W-1:0]    depth_q;
    logic [DEPTH_W-1:0]    depth_d;

    assign full  = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;

    always_comb begin
        top = '0;
        for (int i = 0; i < int'(STACK_DEPTH); i++) begin
            if (depth_q == DEPTH_W'(i + 1)) begin
                top = mem[i];
            end
        end
    end

    always_comb begin
        depth_d = depth_q;
        if (push && !full) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (pop && !empty) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                if (depth_q == DEPTH_W'(i)) begin
                    mem[i] <= push_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/program_counter.sv
// SAP2 program counter: increment, conditional jump/call on latched ALU flags,
// and return through an internal stack with sticky overflow/underflow flags.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned STACK_DEPTH = 4,
    localparam int unsigned DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  i_inc,
    input  logic                  i_jump,
    input  logic                  i_call,
    input  logic                  i_ret,
    input  logic [COND_WIDTH-1:0] i_cond,
    input  logic [ADDR_WIDTH-1:0] i_target,
    input  logic                  i_zero,
    input  logic                  i_carry,
    input  logic                  i_odd,
    input  logic                  i_clr_err,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic                  o_taken,
    output logic [DEPTH_W-1:0]    o_depth,
    output logic                  o_stack_ovf,
    output logic                  o_stack_unf
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  ovf_q, unf_q;
    logic                  ovf_set, unf_set;
    logic                  push, pop;
    logic [ADDR_WIDTH-1:0] stack_top;
    logic                  stack_full, stack_empty;

    assign o_taken = cond_taken(i_cond, i_zero, i_carry, i_odd);

    // Priority chain: ret > call > jump > inc; an untaken call or jump falls through.
    always_comb begin
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (i_ret) begin
            if (!stack_empty) begin
                pop  = 1'b1;
                pc_d = stack_top;
            end else begin
                unf_set = 1'b1;
            end
        end else if (i_call && o_taken) begin
            if (!stack_full) begin
                push = 1'b1;
                pc_d = i_target;
            end else begin
                ovf_set = 1'b1;
            end
        end else if (i_jump && o_taken) begin
            pc_d = i_target;
        end else if (i_inc) begin
            pc_d = pc_q + ADDR_WIDTH'(1);
        end
    end

    return_stack #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_return_stack (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push && clk_en),
        .pop      (pop && clk_en),
        .push_data(pc_q),
        .top      (stack_top),
        .full     (stack_full),
        .empty    (stack_empty),
        .depth    (o_depth)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (clk_en) begin
            pc_q  <= pc_d;
            ovf_q <= ovf_set | (ovf_q & ~i_clr_err);
            unf_q <= unf_set | (unf_q & ~i_clr_err);
        end
    end

    assign o_pc        = pc_q;
    assign o_stack_ovf = ovf_q;
    assign o_stack_unf = unf_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: counting, jumps, call/return nesting,
// command priority, clock enable, sticky errors and asynchronous reset.
module tb_program_counter;

    localparam int unsigned AW = 8;
    localparam int unsigned SD = 4;
    localparam int unsigned DW = 3;

    logic          clk;
    logic          rst_n;
    logic          clk_en;
    logic          i_inc, i_jump, i_call, i_ret;
    logic [2:0]    i_cond;
    logic [AW-1:0] i_target;
    logic          i_zero, i_carry, i_odd;
    logic          i_clr_err;
    logic [AW-1:0] o_pc;
    logic          o_taken;
    logic [DW-1:0] o_depth;
    logic          o_stack_ovf, o_stack_unf;

    int errors = 0;
    int checks = 0;

    program_counter #(
        .ADDR_WIDTH (AW),
        .STACK_DEPTH(SD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .i_inc      (i_inc),
        .i_jump     (i_jump),
        .i_call     (i_call),
        .i_ret      (i_ret),
        .i_cond     (i_cond),
        .i_target   (i_target),
        .i_zero     (i_zero),
        .i_carry    (i_carry),
        .i_odd      (i_odd),
        .i_clr_err  (i_clr_err),
        .o_pc       (o_pc),
        .o_taken    (o_taken),
        .o_depth    (o_depth),
        .o_stack_ovf(o_stack_ovf),
        .o_stack_unf(o_stack_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        i_inc = 0; i_jump = 0; i_call = 0; i_ret = 0; i_clr_err = 0;
        i_cond = 3'd0; i_target = '0;
    endtask

    // Advance one edge and settle past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic jump_to(input logic [AW-1:0] a);
        i_jump = 1; i_cond = 3'd0; i_target = a;
        tick();
    endtask

    task automatic call_to(input logic [AW-1:0] a);
        i_call = 1; i_cond = 3'd0; i_target = a;
        tick();
    endtask

    task automatic test_reset();
        checks++; if (o_pc !== 8'h00) begin errors++; $display("FAIL reset_pc got=%h exp=00", o_pc); end
        checks++; if (o_depth !== 3'd0) begin errors++; $display("FAIL reset_depth got=%0d exp=0", o_depth); end
        checks++; if (o_stack_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", o_stack_ovf); end
        checks++; if (o_stack_unf !== 1'b0) begin errors++; $display("FAIL reset_unf got=%b exp=0", o_stack_unf); end
    endtask

    task automatic test_inc_wrap();
        logic [AW-1:0] exp;
        for (int n = 1; n <= 257; n++) begin
            i_inc = 1;
            tick();
            exp = AW'(n % 256);
            checks++;
            if (o_pc !== exp) begin
                errors++; $display("FAIL inc_wrap step=%0d got=%h exp=%h", n, o_pc, exp);
            end
        end
        checks++; if (o_pc !== 8'h01) begin errors++; $display("FAIL inc_final got=%h exp=01", o_pc); end
    endtask

    task automatic test_taken_table();
        logic exp;
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                i_cond = 3'(c);
                i_zero = f[2]; i_carry = f[1]; i_odd = f[0];
                #1;
                case (c)
                    0: exp = 1'b1;
                    1: exp = f[2];
                    2: exp = !f[2];
                    3: exp = f[1];
                    4: exp = !f[1];
                    5: exp = f[0];
                    6: exp = !f[0];
                    default: exp = 1'b0;
                endcase
                checks++;
                if (o_taken !== exp) begin
                    errors++; $display("FAIL taken cond=%0d flags=%0d got=%b exp=%b", c, f, o_taken, exp);
                end
            end
        end
        i_zero = 0; i_carry = 0; i_odd = 0; i_cond = 3'd0;
    endtask

    task automatic test_jump();
        jump_to(8'h10);
        checks++; if (o_pc !== 8'h10) begin errors++; $display("FAIL jump_always got=%h exp=10", o_pc); end
        i_jump = 1; i_cond = 3'd1; i_zero = 0; i_inc = 1; i_target = 8'h80;
        tick();
        checks++; if (o_pc !== 8'h11) begin errors++; $display("FAIL jump_z_not_taken got=%h exp=11", o_pc); end
        i_jump = 1; i_cond = 3'd1; i_zero = 1; i_inc = 1; i_target = 8'h80;
        tick();
        checks++; if (o_pc !== 8'h80) begin errors++; $display("FAIL jump_z_taken got=%h exp=80", o_pc); end
        i_jump = 1; i_cond = 3'd2; i_target = 8'h55;
        tick();
        checks++; if (o_pc !== 8'h80) begin errors++; $display("FAIL jump_nz_hold got=%h exp=80", o_pc); end
        i_zero = 0;
    endtask

    task automatic test_call_ret();
        jump_to(8'h22);
        call_to(8'h40);
        checks++; if (o_pc !== 8'h40) begin errors++; $display("FAIL call_pc got=%h exp=40", o_pc); end
        checks++; if (o_depth !== 3'd1) begin errors++; $display("FAIL call_depth got=%0d exp=1", o_depth); end
        i_call = 1; i_cond = 3'd7; i_inc = 1; i_target = 8'h99;
        tick();
        checks++; if (o_pc !== 8'h41) begin errors++; $display("FAIL call_never_inc got=%h exp=41", o_pc); end
        checks++; if (o_depth !== 3'd1) begin errors++; $display("FAIL call_never_depth got=%0d exp=1", o_depth); end
        i_ret = 1;
        tick();
        checks++; if (o_pc !== 8'h22) begin errors++; $display("FAIL ret_pc got=%h exp=22", o_pc); end
        checks++; if (o_depth !== 3'd0) begin errors++; $display("FAIL ret_depth got=%0d exp=0", o_depth); end
    endtask

    task automatic test_nested();
        logic [AW-1:0] ret_exp [4];
        ret_exp[0] = 8'h30; ret_exp[1] = 8'h20; ret_exp[2] = 8'h10; ret_exp[3] = 8'h01;
        jump_to(8'h01);
        for (int k = 1; k <= 4; k++) call_to(AW'(k * 16));
        checks++; if (o_depth !== 3'd4) begin errors++; $display("FAIL nest_depth got=%0d exp=4", o_depth); end
        call_to(8'h50);
        checks++; if (o_pc !== 8'h40) begin errors++; $display("FAIL ovf_pc got=%h exp=40", o_pc); end
        checks++; if (o_stack_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", o_stack_ovf); end
        checks++; if (o_depth !== 3'd4) begin errors++; $display("FAIL ovf_depth got=%0d exp=4", o_depth); end
        for (int k = 0; k < 4; k++) begin
            i_ret = 1;
            tick();
            checks++;
            if (o_pc !== ret_exp[k] || o_depth !== DW'(3 - k)) begin
                errors++;
                $display("FAIL lifo_ret%0d got pc=%h depth=%0d exp pc=%h depth=%0d",
                         k, o_pc, o_depth, ret_exp[k], 3 - k);
            end
        end
        i_ret = 1;
        tick();
        checks++; if (o_pc !== 8'h01) begin errors++; $display("FAIL unf_pc got=%h exp=01", o_pc); end
        checks++; if (o_stack_unf !== 1'b1) begin errors++; $display("FAIL unf_flag got=%b exp=1", o_stack_unf); end
        // Clear racing a new underflow: the error must win.
        i_ret = 1; i_clr_err = 1;
        tick();
        checks++; if (o_stack_unf !== 1'b1) begin errors++; $display("FAIL clr_vs_err_unf got=%b exp=1", o_stack_unf); end
        checks++; if (o_stack_ovf !== 1'b0) begin errors++; $display("FAIL clr_vs_err_ovf got=%b exp=0", o_stack_ovf); end
        i_clr_err = 1;
        tick();
        checks++; if (o_stack_unf !== 1'b0) begin errors++; $display("FAIL clr_unf got=%b exp=0", o_stack_unf); end
    endtask

    task automatic test_priority();
        jump_to(8'h05);
        call_to(8'h60);
        i_ret = 1; i_call = 1; i_inc = 1; i_jump = 1; i_cond = 3'd0; i_target = 8'h70;
        tick();
        checks++; if (o_pc !== 8'h05) begin errors++; $display("FAIL prio_pc got=%h exp=05", o_pc); end
        checks++; if (o_depth !== 3'd0) begin errors++; $display("FAIL prio_depth got=%0d exp=0", o_depth); end
    endtask

    task automatic test_clk_en();
        i_ret = 1;
        tick();
        call_to(8'h33);
        clk_en = 0;
        i_ret = 1; i_call = 1; i_jump = 1; i_inc = 1; i_clr_err = 1; i_target = 8'hAA;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        idle();
        checks++; if (o_pc !== 8'h33) begin errors++; $display("FAIL en_pc got=%h exp=33", o_pc); end
        checks++; if (o_depth !== 3'd1) begin errors++; $display("FAIL en_depth got=%0d exp=1", o_depth); end
        checks++; if (o_stack_unf !== 1'b1) begin errors++; $display("FAIL en_unf got=%b exp=1", o_stack_unf); end
        clk_en = 1;
        i_inc = 1;
        tick();
        checks++; if (o_pc !== 8'h34) begin errors++; $display("FAIL en_resume got=%h exp=34", o_pc); end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (o_pc !== 8'h00 || o_depth !== 3'd0 || o_stack_ovf !== 1'b0 || o_stack_unf !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got pc=%h depth=%0d ovf=%b unf=%b exp all 0",
                     o_pc, o_depth, o_stack_ovf, o_stack_unf);
        end
        @(negedge clk);
        rst_n = 1;
        i_inc = 1;
        tick();
        checks++; if (o_pc !== 8'h01) begin errors++; $display("FAIL post_reset_inc got=%h exp=01", o_pc); end
    endtask

    initial begin
        rst_n = 0; clk_en = 1;
        i_zero = 0; i_carry = 0; i_odd = 0;
        idle();
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1;
        test_inc_wrap();
        test_taken_table();
        test_jump();
        test_call_ret();
        test_nested();
        test_priority();
        test_clk_en();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
